// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared constants and types for the LFSR crypt engine
package crypt_pkg;

    localparam logic [7:0] SPACE = 8'h20;

    localparam logic [7:0] TAPS [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } crypt_mode_e;

    typedef enum logic [3:0] {
        IDLE,
        LD_PARAM,
        ENC_RD,
        ENC_WR,
        DEC_RD0,
        SEARCH,
        DEC_SKIP,
        DEC_WR,
        DONE
    } crypt_state_e;

endpackage

// File: rtl/crypt_lfsr.sv
// rtl/crypt_lfsr.sv - loadable Fibonacci-style LFSR, shift left with parity feedback
module crypt_lfsr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] init_i,
    input  logic         step_i,
    input  logic [W-1:0] ptrn_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] s_q;

    // load wins over step so a new candidate can be started in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= '0;
        end else if (load_i) begin
            s_q <= init_i;
        end else if (step_i) begin
            s_q <= {s_q[W-2:0], ^(s_q & ptrn_i)};
        end
    end

    assign state_o = s_q;

endmodule

// File: rtl/lfsr_crypt_engine.sv
// rtl/lfsr_crypt_engine.sv - LFSR stream-cipher encrypt/decrypt engine on data_mem (optional CRYPT_DBG_EN)
module lfsr_crypt_engine
    import crypt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int MSG_LEN    = 41,
    parameter int FRAME_LEN  = 64,
    parameter int SRC_BASE   = 0,
    parameter int PARAM_BASE = 41,
    parameter int DST_BASE   = 64,
    parameter int SEARCH_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CRYPT_DBG_EN
    ,
    output logic [DATA_W-1:0] dbg_tap,
    output logic [DATA_W-1:0] dbg_init
`endif
);

    localparam logic [ADDR_W-1:0] SRC_A      = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] PARAM_A    = ADDR_W'(PARAM_BASE);
    localparam logic [ADDR_W-1:0] DST_A      = ADDR_W'(DST_BASE);
    localparam logic [DATA_W-1:0] LAST_BYTE  = DATA_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] FRAME_END  = DATA_W'(FRAME_LEN);
    localparam logic [DATA_W-1:0] SRCH_END   = DATA_W'(SEARCH_LEN);
    localparam logic [DATA_W-1:0] SKIP_START = DATA_W'(SEARCH_LEN + 1);
    localparam logic [DATA_W-1:0] MSG_LAST   = DATA_W'(MSG_LEN - 1);
    localparam logic [DATA_W:0]   MSG_LEN_W  = (DATA_W+1)'(MSG_LEN);

    crypt_state_e state_q, state_d;
    logic [1:0]        ph_q, ph_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic [2:0]        k_q, k_d;
    logic [DATA_W-1:0] pre_q, pre_d;
    logic [DATA_W-1:0] ptrn_q, ptrn_d;
    logic [DATA_W-1:0] init_q, init_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              err_q, err_d;

    logic              lfsr_load, lfsr_step;
    logic [DATA_W-1:0] lfsr_init, lfsr_s;
    logic [DATA_W-1:0] dec_byte;
    logic [DATA_W:0]   pre_end;
    logic              is_pad;
    logic [ADDR_W-1:0] src_addr;
    logic [2:0]        k_next;

    crypt_lfsr #(.W(DATA_W)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load_i (lfsr_load),
        .init_i (lfsr_init),
        .step_i (lfsr_step),
        .ptrn_i (ptrn_q),
        .state_o(lfsr_s)
    );

    assign dec_byte = mem_rdata ^ lfsr_s;
    assign pre_end  = {1'b0, pre_q} + MSG_LEN_W;
    assign is_pad   = ({1'b0, cnt_q} < {1'b0, pre_q}) || ({1'b0, cnt_q} >= pre_end);
    assign src_addr = SRC_A + ADDR_W'(cnt_q - pre_q);
    assign k_next   = k_q + 3'd1;

    // next-state, datapath and memory port decode; reads use ph 0 = addr, ph 1 = data
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        k_d       = k_q;
        pre_d     = pre_q;
        ptrn_d    = ptrn_q;
        init_d    = init_q;
        byte_d    = byte_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        lfsr_init = init_q;
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d = 1'b0;
                    ph_d  = 2'd0;
                    cnt_d = '0;
                    idx_d = '0;
                    k_d   = '0;
                    state_d = (crypt_mode_e'(mode) == DEC) ? DEC_RD0 : LD_PARAM;
                end
            end
            LD_PARAM: begin
                mem_addr = PARAM_A + ADDR_W'(idx_q);
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    ph_d  = 2'd0;
                    idx_d = idx_q + 1'b1;
                    case (idx_q[1:0])
                        2'd0:    pre_d  = mem_rdata;
                        2'd1:    ptrn_d = mem_rdata;
                        default: begin
                            init_d    = mem_rdata;
                            lfsr_load = 1'b1;
                            lfsr_init = mem_rdata;
                            state_d   = ENC_RD;
                        end
                    endcase
                end
            end
            ENC_RD: begin
                if (!is_pad) mem_addr = src_addr;
                if (ph_q == 2'd0) begin
                    if (is_pad) begin
                        byte_d  = SPACE;
                        state_d = ENC_WR;
                    end else begin
                        ph_d = 2'd1;
                    end
                end else begin
                    byte_d  = mem_rdata;
                    ph_d    = 2'd0;
                    state_d = ENC_WR;
                end
            end
            ENC_WR: begin
                mem_wr    = 1'b1;
                mem_addr  = DST_A + ADDR_W'(cnt_q);
                mem_wdata = byte_q ^ lfsr_s;
                lfsr_step = 1'b1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ENC_RD;
                end
            end
            DEC_RD0: begin
                mem_addr = DST_A;
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    ph_d      = 2'd0;
                    init_d    = mem_rdata ^ SPACE;
                    lfsr_load = 1'b1;
                    lfsr_init = mem_rdata ^ SPACE;
                    k_d       = '0;
                    ptrn_d    = TAPS[0];
                    idx_d     = DATA_W'(1);
                    state_d   = SEARCH;
                end
            end
            SEARCH: begin
                mem_addr = DST_A + ADDR_W'(idx_q);
                if (ph_q == 2'd0) begin
                    lfsr_step = 1'b1;
                    ph_d      = 2'd1;
                end else begin
                    ph_d = 2'd0;
                    if (dec_byte == SPACE) begin
                        if (idx_q == SRCH_END) begin
                            cnt_d   = SKIP_START;
                            state_d = DEC_SKIP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else if (k_q == 3'd7) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        k_d       = k_next;
                        ptrn_d    = TAPS[k_next];
                        lfsr_load = 1'b1;
                        lfsr_init = init_q;
                        idx_d     = DATA_W'(1);
                    end
                end
            end
            DEC_SKIP: begin
                if (ph_q == 2'd0) begin
                    if (cnt_q == FRAME_END) begin
                        byte_d  = SPACE;
                        idx_d   = '0;
                        state_d = DEC_WR;
                    end else begin
                        mem_addr  = DST_A + ADDR_W'(cnt_q);
                        lfsr_step = 1'b1;
                        ph_d      = 2'd1;
                    end
                end else begin
                    mem_addr = DST_A + ADDR_W'(cnt_q);
                    ph_d     = 2'd0;
                    if (dec_byte == SPACE) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        byte_d  = dec_byte;
                        idx_d   = '0;
                        state_d = DEC_WR;
                    end
                end
            end
            DEC_WR: begin
                case (ph_q)
                    2'd0: begin
                        mem_wr    = 1'b1;
                        mem_addr  = SRC_A + ADDR_W'(idx_q);
                        mem_wdata = byte_q;
                        if (idx_q == MSG_LAST) begin
                            state_d = DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            if (cnt_q < LAST_BYTE) begin
                                cnt_d = cnt_q + 1'b1;
                                ph_d  = 2'd1;
                            end else begin
                                byte_d = SPACE;
                            end
                        end
                    end
                    2'd1: begin
                        mem_addr  = DST_A + ADDR_W'(cnt_q);
                        lfsr_step = 1'b1;
                        ph_d      = 2'd2;
                    end
                    default: begin
                        mem_addr = DST_A + ADDR_W'(cnt_q);
                        byte_d   = dec_byte;
                        ph_d     = 2'd0;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            pre_q   <= '0;
            ptrn_q  <= '0;
            init_q  <= '0;
            byte_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            pre_q   <= pre_d;
            ptrn_q  <= ptrn_d;
            init_q  <= init_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);
    assign err  = err_q;

`ifdef CRYPT_DBG_EN
    logic [DATA_W-1:0] dbg_tap_q, dbg_init_q;
    logic              dbg_cap;

    assign dbg_cap = ((state_d == ENC_RD) && (state_q != ENC_RD)) ||
                     ((state_d == DEC_SKIP) && (state_q != DEC_SKIP));

    // snapshot the pattern/init actually used once the keystream is settled
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_tap_q  <= '0;
            dbg_init_q <= '0;
        end else if (dbg_cap) begin
            dbg_tap_q  <= ptrn_d;
            dbg_init_q <= init_d;
        end
    end

    assign dbg_tap  = dbg_tap_q;
    assign dbg_init = dbg_init_q;
`endif

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb/tb_lfsr_crypt_engine.sv - self-checking bench for lfsr_crypt_engine
module tb_lfsr_crypt_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       busy, done, err, mem_wr;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CRYPT_DBG_EN
    logic [7:0] dbg_tap, dbg_init;
`endif

    always #5 clk = ~clk;

    lfsr_crypt_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef CRYPT_DBG_EN
        ,
        .dbg_tap  (dbg_tap),
        .dbg_init (dbg_init)
`endif
    );

    logic [7:0] mem [0:255];
    logic       tb_wr = 1'b0;
    logic [7:0] tb_waddr = 8'd0;
    logic [7:0] tb_wdata = 8'd0;
    int         wr_count = 0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end else if (tb_wr) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] taps [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};
    logic [7:0] msg [41];
    logic [7:0] frame_exp [64];
    logic [7:0] dec_exp [41];
    logic       dec_err_exp;

    function automatic logic [7:0] nxt(input logic [7:0] s, input logic [7:0] p);
        return {s[6:0], ^(s & p)};
    endfunction

    task automatic model_encrypt(input int pre, input logic [7:0] ptrn, input logic [7:0] init);
        logic [7:0] s, p;
        s = init;
        for (int i = 0; i < 64; i++) begin
            p = (i < pre || i >= pre + 41) ? 8'h20 : msg[i - pre];
            frame_exp[i] = p ^ s;
            s = nxt(s, ptrn);
        end
    endtask

    task automatic model_decrypt();
        logic [7:0] init, s;
        logic [7:0] d [64];
        int found, first;
        bit ok;
        init = frame_exp[0] ^ 8'h20;
        found = -1;
        for (int k = 0; k < 8; k++) begin
            if (found < 0) begin
                s = init;
                ok = 1'b1;
                for (int j = 1; j <= 8; j++) begin
                    s = nxt(s, taps[k]);
                    if ((frame_exp[j] ^ s) != 8'h20) ok = 1'b0;
                end
                if (ok) found = k;
            end
        end
        dec_err_exp = (found < 0);
        if (found >= 0) begin
            s = init;
            for (int i = 0; i < 64; i++) begin
                d[i] = frame_exp[i] ^ s;
                s = nxt(s, taps[found]);
            end
            first = 64;
            for (int i = 63; i >= 0; i--) if (d[i] != 8'h20) first = i;
            for (int n = 0; n < 41; n++) dec_exp[n] = (first + n < 64) ? d[first + n] : 8'h20;
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_wr = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    task automatic load_enc(input logic [7:0] pre, input logic [7:0] ptrn, input logic [7:0] init);
        for (int i = 0; i < 41; i++) poke(8'(i), msg[i]);
        poke(8'd41, pre);
        poke(8'd42, ptrn);
        poke(8'd43, init);
    endtask

    task automatic fill_frame(input bit invert);
        for (int i = 0; i < 64; i++) poke(8'(64 + i), invert ? ~frame_exp[i] : frame_exp[i]);
    endtask

    task automatic clear_src();
        for (int i = 0; i < 41; i++) poke(8'(i), 8'h00);
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = done;
    endtask

    task automatic set_msg(input string str);
        for (int i = 0; i < 41; i++) msg[i] = str[i];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
`ifdef CRYPT_DBG_EN
        checks++; if (dbg_tap !== 8'h00 || dbg_init !== 8'h00) begin errors++; $display("FAIL reset_dbg: got %h/%h want 00/00", dbg_tap, dbg_init); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt();
        logic [7:0] init;
        bit ok;
        int cyc;
        init = 8'($urandom_range(1, 255));
        set_msg("Mr. Watson, come here. I want to see you.");
        model_encrypt(9, 8'he1, init);
        load_enc(8'd9, 8'he1, init);
        fill_frame(1'b1);
        pulse_start(1'b0);
        wait_done(400, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL enc_timeout: done=%b after %0d cycles want 1", done, cyc); end
        checks++; if (cyc > 199) begin errors++; $display("FAIL enc_latency: got %0d cycles want <= 199", cyc); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (mem[64 + i] !== frame_exp[i]) begin errors++; $display("FAIL enc_frame[%0d]: got %h want %h", i, mem[64 + i], frame_exp[i]); end
        end
`ifdef CRYPT_DBG_EN
        checks++; if (dbg_tap !== 8'he1 || dbg_init !== init) begin errors++; $display("FAIL enc_dbg: got %h/%h want e1/%h", dbg_tap, dbg_init, init); end
`endif
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL enc_done_hold: got done=%b busy=%b err=%b want 1 0 0", done, busy, err); end
    endtask

    task automatic test_decrypt_plain();
        string expect_s;
        bit ok;
        int cyc;
        expect_s = "Knowledge comes, but wisdom lingers.     ";
        set_msg(expect_s);
        model_encrypt(9, 8'hb8, 8'($urandom_range(1, 255)));
        fill_frame(1'b0);
        clear_src();
        pulse_start(1'b1);
        wait_done(1000, ok, cyc);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL dec_plain_status: got done=%b err=%b want 1 0", done, err); end
        for (int n = 0; n < 41; n++) begin
            checks++;
            if (mem[n] !== 8'(expect_s[n])) begin errors++; $display("FAIL dec_plain[%0d]: got %h want %h", n, mem[n], expect_s[n]); end
        end
`ifdef CRYPT_DBG_EN
        checks++; if (dbg_tap !== 8'hb8) begin errors++; $display("FAIL dec_dbg_tap: got %h want b8", dbg_tap); end
`endif
    endtask

    task automatic test_decrypt_strip();
        string expect_s;
        bit ok;
        int cyc;
        expect_s = "f       A joke is a very serious thing.  ";
        set_msg("  f       A joke is a very serious thing.");
        model_encrypt(10, 8'hf3, 8'($urandom_range(1, 255)));
        fill_frame(1'b0);
        clear_src();
        pulse_start(1'b1);
        wait_done(1000, ok, cyc);
        checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL dec_strip_status: got done=%b err=%b want 1 0", done, err); end
        for (int n = 0; n < 41; n++) begin
            checks++;
            if (mem[n] !== 8'(expect_s[n])) begin errors++; $display("FAIL dec_strip[%0d]: got %h want %h", n, mem[n], expect_s[n]); end
        end
    endtask

    task automatic test_no_tap();
        bit ok;
        int cyc, w0;
        for (int i = 0; i < 64; i++) frame_exp[i] = 8'($urandom);
        fill_frame(1'b0);
        w0 = wr_count;
        pulse_start(1'b1);
        wait_done(1000, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL notap_done: got %b want 1", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL notap_err: got %b want 1", err); end
        checks++; if (wr_count - w0 != 0) begin errors++; $display("FAIL notap_writes: got %0d want 0", wr_count - w0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] init;
        bit ok;
        int cyc, w0;
        init = 8'($urandom_range(1, 255));
        for (int i = 0; i < 41; i++) msg[i] = 8'($urandom_range(32, 126));
        model_encrypt(12, 8'hc6, init);
        load_enc(8'd12, 8'hc6, init);
        fill_frame(1'b1);
        pulse_start(1'b0);
        cyc = 0;
        while (!(mem_wr && mem_addr == 8'd84) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (!(mem_wr && mem_addr == 8'd84)) begin errors++; $display("FAIL mid_reach_byte20: addr=%h wr=%b want 54/1", mem_addr, mem_wr); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got busy=%b done=%b wr=%b want 0 0 0", busy, done, mem_wr); end
        w0 = wr_count;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (wr_count != w0) begin errors++; $display("FAIL mid_no_writes: got %0d want 0", wr_count - w0); end
        checks++; if (mem[85] !== ~frame_exp[21]) begin errors++; $display("FAIL mid_byte21_untouched: got %h want %h", mem[85], ~frame_exp[21]); end
        pulse_start(1'b0);
        wait_done(400, ok, cyc);
        checks++; if (!ok) begin errors++; $display("FAIL mid_restart_done: got %b want 1", done); end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (mem[64 + i] !== frame_exp[i]) begin errors++; $display("FAIL mid_restart[%0d]: got %h want %h", i, mem[64 + i], frame_exp[i]); end
        end
    endtask

    task automatic test_sweep_taps();
        logic [7:0] init;
        int pre, cyc;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            init = 8'($urandom_range(1, 255));
            pre = $urandom_range(9, 40);
            msg[0] = 8'($urandom_range(33, 126));
            for (int i = 1; i < 41; i++) msg[i] = 8'($urandom_range(32, 126));
            model_encrypt(pre, taps[k], init);
            load_enc(8'(pre), taps[k], init);
            fill_frame(1'b1);
            pulse_start(1'b0);
            repeat (10) @(negedge clk);
            pulse_start(1'b1);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep%0d_busy_start: got %b want 1", k, busy); end
            wait_done(400, ok, cyc);
            checks++; if (!ok) begin errors++; $display("FAIL sweep%0d_enc_done: got %b want 1", k, done); end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (mem[64 + i] !== frame_exp[i]) begin errors++; $display("FAIL sweep%0d_frame[%0d]: got %h want %h", k, i, mem[64 + i], frame_exp[i]); end
            end
            model_decrypt();
            clear_src();
            pulse_start(1'b1);
            wait_done(1000, ok, cyc);
            checks++; if (!ok || err !== dec_err_exp) begin errors++; $display("FAIL sweep%0d_dec_status: got done=%b err=%b want 1 %b", k, done, err, dec_err_exp); end
            if (!dec_err_exp) begin
                for (int n = 0; n < 41; n++) begin
                    checks++;
                    if (mem[n] !== dec_exp[n]) begin errors++; $display("FAIL sweep%0d_plain[%0d]: got %h want %h", k, n, mem[n], dec_exp[n]); end
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_encrypt();
        test_decrypt_plain();
        test_decrypt_strip();
        test_no_tap();
        test_reset_mid();
        test_sweep_taps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
